fault_sense_fsm: RTL and testbench

- Host-side monitor for the shared open-drain nFault line driven by the subsystem error FSMs.
- After each register transaction (register_address_valid high then low), waits a settle window, samples the synchronised line and reports the result to the command layer.
- Keeps a sticky fault flag and a saturating fault counter.
- Flags a bus-stuck condition when nFault stays low while no transaction is in progress.

---
 rtl/fault_sense_fsm_if.sv | 25 ++
 rtl/fault_sense_fsm.sv | 133 +++++++++++++
 tb/tb_fault_sense_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fault_sense_fsm_if.sv
// Bundles the command-layer signals of the nFault monitor.
// master: transaction strobe, raw nFault line and clear request out; results in.
// slave : the monitor; takes those inputs and returns sample/fault/stuck status.
interface fault_sense_fsm_if #(
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   register_address_valid;
    logic                   nFault_in;
    logic                   clear_fault;
    logic                   sample_valid;
    logic                   fault_detected;
    logic                   fault_sticky;
    logic [COUNT_WIDTH-1:0] fault_count;
    logic                   bus_stuck;

    modport master (
        output register_address_valid, nFault_in, clear_fault,
        input  sample_valid, fault_detected, fault_sticky, fault_count, bus_stuck
    );

    modport slave (
        input  register_address_valid, nFault_in, clear_fault,
        output sample_valid, fault_detected, fault_sticky, fault_count, bus_stuck
    );
endinterface

// File: rtl/fault_sense_fsm.sv
// Host-side monitor of the shared open-drain nFault line.
// After each register transaction it waits a settle window, samples the
// synchronised line, and reports via a one-cycle sample_valid pulse. Keeps a
// sticky fault flag, a saturating fault counter and an idle bus-stuck flag.
// Ports: clk, reset (sync, active-high), bus (fault_sense_fsm_if.slave).
module fault_sense_fsm #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES  = 64,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    fault_sense_fsm_if.slave  bus
);
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned STUCK_W  = $clog2(STUCK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_F0 = 3'd0,   // idle
        S_F1 = 3'd1,   // transaction active
        S_F2 = 3'd2,   // settle
        S_F3 = 3'd3,   // sample
        S_F4 = 3'd4    // report
    } state_t;

    state_t                 state, state_next;
    logic                   sync1, nf_s;
    logic [SETTLE_W-1:0]    settle_cnt, settle_next;
    logic [STUCK_W-1:0]     stuck_cnt, stuck_next;
    logic                   sample_valid_next;
    logic                   detected_next;
    logic                   sticky_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   bus_stuck_next;

    // Register stage: state, synchroniser, counters and all outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_F0;
            sync1              <= 1'b1;
            nf_s               <= 1'b1;
            settle_cnt         <= '0;
            stuck_cnt          <= '0;
            bus.sample_valid   <= 1'b0;
            bus.fault_detected <= 1'b0;
            bus.fault_sticky   <= 1'b0;
            bus.fault_count    <= '0;
            bus.bus_stuck      <= 1'b0;
        end else begin
            state              <= state_next;
            sync1              <= bus.nFault_in;
            nf_s               <= sync1;
            settle_cnt         <= settle_next;
            stuck_cnt          <= stuck_next;
            bus.sample_valid   <= sample_valid_next;
            bus.fault_detected <= detected_next;
            bus.fault_sticky   <= sticky_next;
            bus.fault_count    <= count_next;
            bus.bus_stuck      <= bus_stuck_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next        = state;
        settle_next       = settle_cnt;
        stuck_next        = '0;
        sample_valid_next = 1'b0;
        detected_next     = bus.fault_detected;
        sticky_next       = bus.fault_sticky;
        count_next        = bus.fault_count;
        bus_stuck_next    = bus.bus_stuck;

        // Clear is applied first so a fault sampled in the same cycle wins
        if (bus.clear_fault) begin
            sticky_next = 1'b0;
            count_next  = '0;
            if (nf_s) begin
                bus_stuck_next = 1'b0;
            end
        end

        case (state)
            S_F0: begin
                // Stuck monitor: count idle low cycles, hold once threshold is reached
                if (!nf_s) begin
                    if (stuck_cnt == STUCK_W'(STUCK_CYCLES)) begin
                        stuck_next = stuck_cnt;
                    end else begin
                        stuck_next = stuck_cnt + STUCK_W'(1);
                    end
                    if (stuck_cnt == STUCK_W'(STUCK_CYCLES - 1)) begin
                        bus_stuck_next = 1'b1;
                    end
                end
                if (bus.register_address_valid) begin
                    state_next = S_F1;
                end
            end
            S_F1: begin
                if (!bus.register_address_valid) begin
                    state_next  = S_F2;
                    settle_next = SETTLE_W'(SETTLE_CYCLES - 1);
                end
            end
            S_F2: begin
                if (settle_cnt == '0) begin
                    state_next = S_F3;
                end else begin
                    settle_next = settle_cnt - SETTLE_W'(1);
                end
            end
            S_F3: begin
                detected_next = ~nf_s;
                if (!nf_s) begin
                    sticky_next = 1'b1;
                    if (count_next != '1) begin
                        count_next = count_next + COUNT_WIDTH'(1);
                    end
                end
                // Registered pulse lands in the S_F4 cycle
                sample_valid_next = 1'b1;
                state_next        = S_F4;
            end
            S_F4: begin
                state_next = S_F0;
            end
            default: begin
                state_next = S_F0;
            end
        endcase
    end
endmodule

// File: tb/tb_fault_sense_fsm.sv
// Self-checking bench for fault_sense_fsm: directed steps plus randomized
// transactions against a counting model of the reported fault state.
module tb_fault_sense_fsm;
    localparam int SETTLE = 4;
    localparam int STUCK  = 64;
    localparam int CW     = 8;
    localparam int MAXC   = 255;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    // Reference model of the visible fault state
    int   m_count;
    bit   m_sticky;
    bit   m_det;

    fault_sense_fsm_if #(.COUNT_WIDTH(CW)) bus ();

    fault_sense_fsm #(
        .SETTLE_CYCLES(SETTLE),
        .STUCK_CYCLES (STUCK),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sv"},     32'(bus.sample_valid),   32'd0);
        chk({tag, "_det"},    32'(bus.fault_detected), 32'd0);
        chk({tag, "_sticky"}, 32'(bus.fault_sticky),   32'd0);
        chk({tag, "_count"},  32'(bus.fault_count),    32'd0);
        chk({tag, "_stuck"},  32'(bus.bus_stuck),      32'd0);
    endtask

    // One transaction of len cycles; nf is the line level seen from edge nf_delay
    // after the strobe drops (0 = from the start). clr_f3 pulses clear_fault on
    // the sampling edge. Expected pulse: SETTLE+2 edges after the strobe drops.
    task automatic run_txn(input int len, input bit nf, input int nf_delay,
                           input bit clr_f3, input int gap, input string tag);
        int sv_edge;
        int pulses;
        sv_edge = 0;
        pulses  = 0;
        if (clr_f3) begin
            m_count  = 0;
            m_sticky = 0;
        end
        if (!nf) begin
            m_sticky = 1;
            m_count  = (m_count >= MAXC) ? MAXC : m_count + 1;
        end
        m_det = !nf;

        bus.nFault_in = (nf_delay == 0) ? nf : 1'b1;
        bus.register_address_valid = 1'b1;
        repeat (len) tick();
        bus.register_address_valid = 1'b0;
        for (int k = 1; k <= SETTLE + 4; k++) begin
            if (k == nf_delay) bus.nFault_in = nf;
            bus.clear_fault = clr_f3 && (k == SETTLE + 2);
            tick();
            bus.clear_fault = 1'b0;
            if (bus.sample_valid) begin
                pulses++;
                if (sv_edge == 0) begin
                    sv_edge = k;
                    chk({tag, "_det"},    32'(bus.fault_detected), 32'(m_det));
                    chk({tag, "_sticky"}, 32'(bus.fault_sticky),   32'(m_sticky));
                    chk({tag, "_count"},  32'(bus.fault_count),    32'(m_count));
                end
            end
        end
        chk({tag, "_latency"}, 32'(sv_edge), 32'(SETTLE + 2));
        chk({tag, "_pulses"},  32'(pulses),  32'd1);
        chk({tag, "_det_hold"}, 32'(bus.fault_detected), 32'(m_det));
        bus.nFault_in = 1'b1;
        repeat (gap) tick();
    endtask

    initial begin
        int pulses;
        tests = 0;
        fails = 0;
        m_count = 0;
        m_sticky = 0;
        m_det = 0;
        reset = 1'b1;
        bus.register_address_valid = 1'b0;
        bus.nFault_in = 1'b1;
        bus.clear_fault = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Clean 3-cycle transaction, then a fault driven from T+2
        run_txn(3, 1'b1, 0, 1'b0, 3, "clean");
        run_txn(3, 1'b0, 2, 1'b0, 3, "fault");

        // Randomized transactions
        for (int i = 0; i < 30; i++) begin
            run_txn(int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)), 0, 1'b0,
                    int'($urandom_range(1, 4)), "rand");
        end

        // Clear, then saturate the counter
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        m_count = 0;
        m_sticky = 0;
        chk("clr_sticky", 32'(bus.fault_sticky), 32'd0);
        chk("clr_count",  32'(bus.fault_count),  32'd0);
        for (int i = 0; i < 256; i++) begin
            run_txn(2, 1'b0, 0, 1'b0, 1, "sat");
        end
        chk("sat_final", 32'(bus.fault_count), 32'(MAXC));

        // clear_fault coincident with a fault sample: fault wins
        run_txn(2, 1'b0, 0, 1'b1, 2, "clr_vs_fault");

        // Bus stuck while idle
        repeat (4) tick();
        chk("stuck_pre", 32'(bus.bus_stuck), 32'd0);
        bus.nFault_in = 1'b0;
        repeat (STUCK + 1) tick();
        chk("stuck_edge_minus1", 32'(bus.bus_stuck), 32'd0);
        tick();
        chk("stuck_edge", 32'(bus.bus_stuck), 32'd1);
        repeat (4) tick();
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        chk("stuck_clr_low", 32'(bus.bus_stuck), 32'd1);
        bus.nFault_in = 1'b1;
        repeat (3) tick();
        chk("stuck_hold_high", 32'(bus.bus_stuck), 32'd1);
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        chk("stuck_clr_high", 32'(bus.bus_stuck), 32'd0);
        m_count = 0;
        m_sticky = 0;

        // Put a fault on record, then reset mid-settle
        run_txn(2, 1'b0, 0, 1'b0, 2, "pre_rst");
        bus.register_address_valid = 1'b1;
        repeat (2) tick();
        bus.register_address_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst_mid");
        m_count = 0;
        m_sticky = 0;
        m_det = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.sample_valid) pulses++;
        end
        chk("rst_no_pulse", 32'(pulses), 32'd0);
        run_txn(3, 1'b1, 0, 1'b0, 2, "post_rst_clean");
        run_txn(3, 1'b0, 0, 1'b0, 2, "post_rst_fault");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
